data_memory_ctrl: RTL and testbench

Parametrised data memory for the RISC datapath load/store stage. It replaces the fixed 32-bit word-addressed array with a byte-addressed, size-aware memory. The block supports byte/half/word/(double)word accesses, sign or zero extension on loads, and alignment/range error reporting. It uses a valid/ready request handshake with a registered one-cycle response. After reset, a hardware init sequencer clears the array before the first request is accepted.

---
 rtl/data_memory_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressed, size-aware data memory for the load/store stage.
// Clears itself after reset, then serves one request per cycle with a registered response.
module data_memory_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done,
    output logic                  dbg_state
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // its response is presented with rsp_valid high for exactly the following cycle.

    localparam int B      = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(B);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int IDXF_W = ADDR_WIDTH - OFF_W;
    localparam bit DWORD_OK = (DATA_WIDTH == 64);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
    logic               init_we;

    logic [IDXF_W-1:0]     idx_full;
    logic [IDX_W-1:0]      idx;
    logic [OFF_W-1:0]      offset;
    logic [OFF_W-1:0]      align_mask;
    logic [B-1:0]          size_mask;
    logic [B-1:0]          byte_en;
    logic [DATA_WIDTH-1:0] bit_mask;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] rd_sh;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  sign_bit;
    logic                  size_err;
    logic                  mis_err;
    logic                  range_err;
    logic                  req_err;
    logic                  accept;
    logic                  store_we;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + IDX_W'(1);
            if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = (state_q == ST_RUN);
        init_done = (state_q == ST_RUN);
        init_we   = (state_q == ST_INIT);
        dbg_state = state_q;
    end

    // ---------------- Address decode and error checks ----------------
    always_comb begin
        idx_full = req_addr[ADDR_WIDTH-1:OFF_W];
        idx      = idx_full[IDX_W-1:0];
        offset   = req_addr[OFF_W-1:0];

        case (req_size)
            2'd0:    begin align_mask = OFF_W'(0); size_mask = B'(1);   end
            2'd1:    begin align_mask = OFF_W'(1); size_mask = B'(3);   end
            2'd2:    begin align_mask = OFF_W'(3); size_mask = B'(15);  end
            default: begin align_mask = OFF_W'(7); size_mask = B'(255); end
        endcase

        size_err  = (req_size == 2'd3) && !DWORD_OK;
        mis_err   = |(offset & align_mask);
        range_err = (idx_full >= IDXF_W'(DEPTH));
        req_err   = size_err | mis_err | range_err;

        accept    = req_valid & req_ready;
        store_we  = accept & req_write & ~req_err;
        byte_en   = size_mask << offset;
        wdata_sh  = req_wdata << {offset, 3'b000};
    end

    // ---------------- Storage ----------------
    // The array is not reset; the init sequencer clears it word by word instead.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_cnt_q] <= '0;
        end else if (store_we) begin
            for (int b = 0; b < B; b++) begin
                if (byte_en[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // ---------------- Load extraction ----------------
    // Reading the array combinationally at acceptance gives read-after-write for free.
    always_comb begin
        rd_sh = mem_q[idx] >> {offset, 3'b000};
        for (int b = 0; b < B; b++) begin
            bit_mask[8*b +: 8] = {8{size_mask[b]}};
        end
        case (req_size)
            2'd0:    sign_bit = rd_sh[7];
            2'd1:    sign_bit = rd_sh[15];
            2'd2:    sign_bit = rd_sh[31];
            default: sign_bit = rd_sh[DATA_WIDTH-1];
        endcase
        // A full-width access has an all-ones mask, so the extension term vanishes.
        load_val = (rd_sh & bit_mask) | ((sign_bit && !req_unsigned) ? ~bit_mask : '0);
    end

    // ---------------- Response ----------------
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            rsp_rdata_d = (req_err || req_write) ? '0 : load_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one 32-bit and one 64-bit instance
// sharing clock and reset, checked with immediate assertions.
module tb_data_memory_ctrl;

    logic clk;
    logic rst_n;

    logic        v32, w32, u32, rdy32, rv32, re32, id32, st32;
    logic [31:0] a32, wd32, rd32;
    logic [1:0]  s32;

    logic        v64, w64, u64, rdy64, rv64, re64, id64, st64;
    logic [31:0] a64;
    logic [63:0] wd64, rd64;
    logic [1:0]  s64;

    int checks;
    int failures;
    int cnt;
    logic saw_rsp;

    data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64)) u_dut32 (
        .clk(clk), .reset(rst_n),
        .req_valid(v32), .req_ready(rdy32), .req_write(w32), .req_addr(a32),
        .req_size(s32), .req_unsigned(u32), .req_wdata(wd32),
        .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_err(re32),
        .init_done(id32), .dbg_state(st32)
    );

    data_memory_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(64)) u_dut64 (
        .clk(clk), .reset(rst_n),
        .req_valid(v64), .req_ready(rdy64), .req_write(w64), .req_addr(a64),
        .req_size(s64), .req_unsigned(u64), .req_wdata(wd64),
        .rsp_valid(rv64), .rsp_rdata(rd64), .rsp_err(re64),
        .init_done(id64), .dbg_state(st64)
    );

    // ---------------- Clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- Check helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rsp32(input string tag, input logic [31:0] exp_data, input logic exp_err);
        chk({tag, ".valid"}, 64'(rv32), 64'(1));
        chk({tag, ".data"},  64'(rd32), 64'(exp_data));
        chk({tag, ".err"},   64'(re32), 64'(exp_err));
    endtask

    task automatic rsp64(input string tag, input logic [63:0] exp_data, input logic exp_err);
        chk({tag, ".valid"}, 64'(rv64), 64'(1));
        chk({tag, ".data"},  rd64,      exp_data);
        chk({tag, ".err"},   64'(re64), 64'(exp_err));
    endtask

    // ---------------- Drivers (called at a falling edge) ----------------
    task automatic req32(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd);
        v32 = 1'b1; w32 = wr; a32 = addr; s32 = sz; u32 = uns; wd32 = wd;
        @(negedge clk);
    endtask

    task automatic req64(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [63:0] wd);
        v64 = 1'b1; w64 = wr; a64 = addr; s64 = sz; u64 = uns; wd64 = wd;
        @(negedge clk);
    endtask

    task automatic idle();
        v32 = 1'b0;
        v64 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_init(input string tag);
        cnt = 0;
        saw_rsp = 1'b0;
        while (!rdy32 && cnt < 200) begin
            cnt++;
            @(negedge clk);
            saw_rsp = saw_rsp | rv32 | rv64;
        end
        v32 = 1'b0;
        v64 = 1'b0;
        chk({tag, ".init_cycles"}, 64'(cnt), 64'(64));
        chk({tag, ".no_rsp_in_init"}, 64'(saw_rsp), 64'(0));
        chk({tag, ".init_done32"}, 64'(id32), 64'(1));
        chk({tag, ".ready64"}, 64'(rdy64), 64'(1));
        chk({tag, ".init_done64"}, 64'(id64), 64'(1));
        chk({tag, ".state32"}, 64'(st32), 64'(1));
    endtask

    // ---------------- Directed sequence ----------------
    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        v32 = 1'b0; w32 = 1'b0; a32 = '0; s32 = '0; u32 = 1'b0; wd32 = '0;
        v64 = 1'b0; w64 = 1'b0; a64 = '0; s64 = '0; u64 = 1'b0; wd64 = '0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst.ready32", 64'(rdy32), 64'(0));
        chk("rst.valid32", 64'(rv32),  64'(0));
        chk("rst.data32",  64'(rd32),  64'(0));
        chk("rst.err32",   64'(re32),  64'(0));
        chk("rst.done32",  64'(id32),  64'(0));
        chk("rst.state32", 64'(st32),  64'(0));
        chk("rst.ready64", 64'(rdy64), 64'(0));
        chk("rst.done64",  64'(id64),  64'(0));

        // Release; a store offered during init must be ignored
        rst_n = 1'b1;
        v32 = 1'b1; w32 = 1'b1; a32 = 32'h0; s32 = 2'd2; u32 = 1'b0; wd32 = 32'hFFFF_FFFF;
        v64 = 1'b1; w64 = 1'b1; a64 = 32'h0; s64 = 2'd3; u64 = 1'b0; wd64 = '1;
        wait_init("init1");

        req32(1'b0, 32'h00, 2'd2, 1'b0, '0); rsp32("ld0", 32'h0, 1'b0);
        req32(1'b0, 32'hFC, 2'd2, 1'b0, '0); rsp32("ldFC", 32'h0, 1'b0);

        // Sign/zero extension on byte and half loads
        req32(1'b1, 32'h10, 2'd2, 1'b0, 32'h8081_7F01); rsp32("st10", 32'h0, 1'b0);
        req32(1'b0, 32'h13, 2'd0, 1'b0, '0); rsp32("lb13s", 32'hFFFF_FF80, 1'b0);
        req32(1'b0, 32'h13, 2'd0, 1'b1, '0); rsp32("lb13u", 32'h0000_0080, 1'b0);
        req32(1'b0, 32'h10, 2'd1, 1'b0, '0); rsp32("lh10s", 32'h0000_7F01, 1'b0);
        req32(1'b0, 32'h12, 2'd1, 1'b0, '0); rsp32("lh12s", 32'hFFFF_8081, 1'b0);
        req32(1'b0, 32'h11, 2'd0, 1'b0, '0); rsp32("lb11s", 32'h0000_007F, 1'b0);
        req32(1'b0, 32'h10, 2'd2, 1'b1, '0); rsp32("lw10u", 32'h8081_7F01, 1'b0);

        // Partial stores only touch their lanes
        req32(1'b1, 32'h20, 2'd2, 1'b0, 32'h1122_3344); rsp32("st20", 32'h0, 1'b0);
        req32(1'b1, 32'h21, 2'd0, 1'b0, 32'hFFFF_FFAA); rsp32("sb21", 32'h0, 1'b0);
        req32(1'b0, 32'h20, 2'd2, 1'b0, '0); rsp32("lw20a", 32'h1122_AA44, 1'b0);
        req32(1'b1, 32'h22, 2'd1, 1'b0, 32'h1234_BEEF); rsp32("sh22", 32'h0, 1'b0);
        req32(1'b0, 32'h20, 2'd2, 1'b0, '0); rsp32("lw20b", 32'hBEEF_AA44, 1'b0);
        req32(1'b0, 32'h22, 2'd1, 1'b1, '0); rsp32("lh22u", 32'h0000_BEEF, 1'b0);

        // Error cases
        req32(1'b0, 32'h03, 2'd1, 1'b0, '0);            rsp32("e_mis_h", 32'h0, 1'b1);
        req32(1'b0, 32'h20, 2'd2, 1'b0, '0);            rsp32("lw20c", 32'hBEEF_AA44, 1'b0);
        req32(1'b0, 32'h22, 2'd2, 1'b0, '0);            rsp32("e_mis_w", 32'h0, 1'b1);
        req32(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF); rsp32("e_range_st", 32'h0, 1'b1);
        req32(1'b0, 32'h00, 2'd2, 1'b0, '0);            rsp32("ld0_after", 32'h0, 1'b0);
        req32(1'b0, 32'h200, 2'd0, 1'b0, '0);           rsp32("e_range_ld", 32'h0, 1'b1);
        req32(1'b0, 32'h00, 2'd3, 1'b0, '0);            rsp32("e_size3", 32'h0, 1'b1);
        req32(1'b0, 32'hFF, 2'd0, 1'b0, '0);            rsp32("lbFF", 32'h0, 1'b0);

        // Back-to-back traffic with read-after-write
        req32(1'b1, 32'h30, 2'd2, 1'b0, 32'hCAFE_F00D); rsp32("b2b.st1", 32'h0, 1'b0);
        req32(1'b0, 32'h30, 2'd2, 1'b0, '0);            rsp32("b2b.ld1", 32'hCAFE_F00D, 1'b0);
        req32(1'b1, 32'h30, 2'd0, 1'b0, 32'h0000_0055); rsp32("b2b.st2", 32'h0, 1'b0);
        req32(1'b0, 32'h30, 2'd2, 1'b0, '0);            rsp32("b2b.ld2", 32'hCAFE_F055, 1'b0);
        idle();
        chk("idle.valid32", 64'(rv32), 64'(0));
        chk("idle.hold32",  64'(rd32), 64'(32'hCAFE_F055));

        // 64-bit instance
        req64(1'b1, 32'h08, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF); rsp64("d.st08", 64'h0, 1'b0);
        req64(1'b0, 32'h08, 2'd3, 1'b1, '0); rsp64("d.ld08", 64'h0123_4567_89AB_CDEF, 1'b0);
        req64(1'b0, 32'h0C, 2'd2, 1'b0, '0); rsp64("d.lw0C", 64'h0000_0000_0123_4567, 1'b0);
        req64(1'b0, 32'h08, 2'd2, 1'b0, '0); rsp64("d.lw08s", 64'hFFFF_FFFF_89AB_CDEF, 1'b0);
        req64(1'b0, 32'h08, 2'd2, 1'b1, '0); rsp64("d.lw08u", 64'h0000_0000_89AB_CDEF, 1'b0);
        req64(1'b0, 32'h0F, 2'd0, 1'b0, '0); rsp64("d.lb0F", 64'h0000_0000_0000_0001, 1'b0);
        req64(1'b0, 32'h04, 2'd3, 1'b0, '0); rsp64("d.e_mis", 64'h0, 1'b1);
        req64(1'b0, 32'h200, 2'd3, 1'b0, '0); rsp64("d.e_range", 64'h0, 1'b1);
        idle();
        chk("idle.valid64", 64'(rv64), 64'(0));

        // Reset with a request in flight on both instances
        v32 = 1'b1; w32 = 1'b0; a32 = 32'h10; s32 = 2'd2; u32 = 1'b0;
        v64 = 1'b1; w64 = 1'b0; a64 = 32'h08; s64 = 2'd3; u64 = 1'b0;
        @(posedge clk);
        #1;
        chk("inflight.valid32", 64'(rv32), 64'(1));
        chk("inflight.valid64", 64'(rv64), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("arst.valid32", 64'(rv32), 64'(0));
        chk("arst.data32",  64'(rd32), 64'(0));
        chk("arst.ready32", 64'(rdy32), 64'(0));
        chk("arst.valid64", 64'(rv64), 64'(0));
        chk("arst.done64",  64'(id64), 64'(0));
        v32 = 1'b0;
        v64 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init("init2");

        req32(1'b0, 32'h10, 2'd2, 1'b0, '0); rsp32("clr.lw10", 32'h0, 1'b0);
        req32(1'b0, 32'h30, 2'd2, 1'b0, '0); rsp32("clr.lw30", 32'h0, 1'b0);
        idle();
        req64(1'b0, 32'h08, 2'd3, 1'b0, '0); rsp64("clr.ld08", 64'h0, 1'b0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
